// File: rtl/cpu64_l2_line_seq_pkg.sv
// Shared constants and state encoding for the L2 line sequencer.
// Geometry: 256 sets x 16 ways x 8 words of 64 bits, 50-bit tags.
package cpu64_l2_line_seq_pkg;

  localparam int DATA_W = 64;
  localparam int TAG_W  = 50;
  localparam int IDX_W  = 8;
  localparam int WAY_W  = 4;
  localparam int BEATS  = 8;
  localparam int BEAT_W = 3;
  localparam int BE_W   = 8;

  localparam logic [BE_W-1:0]   FULL_BE   = 8'hFF;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EVICT = 2'd1,
    ST_FILL  = 2'd2
  } state_t;

endpackage

// File: rtl/cpu64_l2_arb3.sv
// Combinational three-way fixed-priority arbiter (ev > fill > word) with a
// boost input that lets a pending word request jump the queue.
module cpu64_l2_arb3 (
  input  logic en,
  input  logic ev_req,
  input  logic fill_req,
  input  logic word_req,
  input  logic word_boost,
  output logic ev_gnt,
  output logic fill_gnt,
  output logic word_gnt
);

  always_comb begin
    // NOTE: every output gets a default before any branch, so no path can
    // leave a value unassigned and infer a latch.
    ev_gnt   = 1'b0;
    fill_gnt = 1'b0;
    word_gnt = 1'b0;
    if (en) begin
      if (word_boost && word_req) word_gnt = 1'b1;
      else if (ev_req)            ev_gnt   = 1'b1;
      else if (fill_req)          fill_gnt = 1'b1;
      else if (word_req)          word_gnt = 1'b1;
    end
  end

endmodule

// File: rtl/cpu64_l2_line_seq.sv
// Sequencer in front of the L2 data/tag arrays: shares the single array port
// between core word accesses, victim eviction bursts and refill bursts.
module cpu64_l2_line_seq
  import cpu64_l2_line_seq_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              word_req_i,
  input  logic              word_we_i,
  input  logic [IDX_W-1:0]  word_index_i,
  input  logic [2:0]        word_sel_i,
  input  logic [WAY_W-1:0]  word_way_i,
  input  logic [BE_W-1:0]   word_be_i,
  input  logic [DATA_W-1:0] word_wdata_i,
  output logic              word_gnt_o,
  output logic [DATA_W-1:0] word_rdata_o,
  input  logic              ev_req_i,
  input  logic [IDX_W-1:0]  ev_index_i,
  input  logic [WAY_W-1:0]  ev_way_i,
  output logic              ev_gnt_o,
  output logic              ev_valid_o,
  input  logic              ev_ready_i,
  output logic [DATA_W-1:0] ev_data_o,
  output logic [TAG_W-1:0]  ev_tag_o,
  output logic              ev_last_o,
  input  logic              fill_req_i,
  input  logic [IDX_W-1:0]  fill_index_i,
  input  logic [WAY_W-1:0]  fill_way_i,
  input  logic [TAG_W-1:0]  fill_tag_i,
  output logic              fill_gnt_o,
  input  logic              fill_valid_i,
  input  logic [DATA_W-1:0] fill_data_i,
  output logic              fill_ready_o,
  output logic              fill_done_o,
  output logic [IDX_W-1:0]  arr_index_o,
  output logic [2:0]        arr_word_sel_o,
  output logic [WAY_W-1:0]  arr_way_sel_o,
  output logic              arr_data_we_o,
  output logic              arr_tag_we_o,
  output logic [BE_W-1:0]   arr_be_o,
  output logic [TAG_W-1:0]  arr_tag_o,
  output logic [DATA_W-1:0] arr_wdata_o,
  input  logic [DATA_W-1:0] arr_rdata_i,
  input  logic [TAG_W-1:0]  arr_tag_i,
  output logic              busy_o
);

  state_t             state_q, state_d;
  logic [BEAT_W-1:0]  beat_q, beat_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [WAY_W-1:0]   way_q, way_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic               word_prio_q, word_prio_d;
  logic               done_q, done_d;
  logic               arb_en, ev_gnt, fill_gnt, word_gnt;

  // Arbitration only happens in IDLE and is masked while reset is asserted.
  assign arb_en = (state_q == ST_IDLE) && !rst_i;

  cpu64_l2_arb3 u_arb (
    .en         (arb_en),
    .ev_req     (ev_req_i),
    .fill_req   (fill_req_i),
    .word_req   (word_req_i),
    .word_boost (word_prio_q),
    .ev_gnt     (ev_gnt),
    .fill_gnt   (fill_gnt),
    .word_gnt   (word_gnt)
  );

  assign word_gnt_o   = word_gnt;
  assign ev_gnt_o     = ev_gnt;
  assign fill_gnt_o   = fill_gnt;
  assign word_rdata_o = arr_rdata_i;
  assign ev_data_o    = arr_rdata_i;
  assign ev_tag_o     = arr_tag_i;
  assign fill_done_o  = done_q;
  assign busy_o       = (state_q != ST_IDLE);

  always_comb begin
    state_d        = state_q;
    beat_d         = beat_q;
    idx_d          = idx_q;
    way_d          = way_q;
    tag_d          = tag_q;
    word_prio_d    = word_prio_q;
    done_d         = 1'b0;
    arr_index_o    = word_index_i;
    arr_word_sel_o = word_sel_i;
    arr_way_sel_o  = word_way_i;
    arr_be_o       = word_be_i;
    arr_wdata_o    = word_wdata_i;
    arr_tag_o      = tag_q;
    arr_data_we_o  = 1'b0;
    arr_tag_we_o   = 1'b0;
    ev_valid_o     = 1'b0;
    ev_last_o      = 1'b0;
    fill_ready_o   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (!word_req_i) word_prio_d = 1'b0;
        if (word_gnt) begin
          arr_data_we_o = word_we_i;
          word_prio_d   = 1'b0;
        end else if (ev_gnt) begin
          idx_d   = ev_index_i;
          way_d   = ev_way_i;
          beat_d  = '0;
          state_d = ST_EVICT;
        end else if (fill_gnt) begin
          idx_d   = fill_index_i;
          way_d   = fill_way_i;
          tag_d   = fill_tag_i;
          beat_d  = '0;
          state_d = ST_FILL;
        end
      end

      ST_EVICT: begin
        arr_index_o    = idx_q;
        arr_way_sel_o  = way_q;
        arr_word_sel_o = beat_q;
        ev_valid_o     = 1'b1;
        ev_last_o      = (beat_q == LAST_BEAT);
        if (ev_ready_i) begin
          beat_d = beat_q + 1'b1;
          if (beat_q == LAST_BEAT) begin
            state_d     = ST_IDLE;
            word_prio_d = 1'b1;
          end
        end
      end

      ST_FILL: begin
        arr_index_o    = idx_q;
        arr_way_sel_o  = way_q;
        arr_word_sel_o = beat_q;
        arr_be_o       = FULL_BE;
        arr_wdata_o    = fill_data_i;
        fill_ready_o   = 1'b1;
        if (fill_valid_i) begin
          arr_data_we_o = 1'b1;
          beat_d        = beat_q + 1'b1;
          // Tag goes in only with the last word so a cut-short fill never
          // leaves a valid-looking tag over partial data.
          if (beat_q == LAST_BEAT) begin
            arr_tag_we_o = 1'b1;
            state_d      = ST_IDLE;
            word_prio_d  = 1'b1;
            done_d       = 1'b1;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its pre-edge inputs regardless of evaluation order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      beat_q      <= '0;
      word_prio_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      word_prio_q <= word_prio_d;
      done_q      <= done_d;
    end
  end

  // NOTE: the latched burst address/tag carries no reset; it is always
  // loaded on a grant before it is used, so a reset would only cost area.
  always_ff @(posedge clk_i) begin
    idx_q <= idx_d;
    way_q <= way_d;
    tag_q <= tag_d;
  end

endmodule

// File: tb/tb_cpu64_l2_line_seq.sv
// Self-checking bench: behavioural array environment plus a transaction-level
// reference image of array contents, randomized data, directed scenarios.
module tb_cpu64_l2_line_seq;
  import cpu64_l2_line_seq_pkg::*;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              word_req_i, word_we_i;
  logic [7:0]        word_index_i;
  logic [2:0]        word_sel_i;
  logic [3:0]        word_way_i;
  logic [7:0]        word_be_i;
  logic [63:0]       word_wdata_i;
  logic              word_gnt_o;
  logic [63:0]       word_rdata_o;
  logic              ev_req_i, ev_ready_i;
  logic [7:0]        ev_index_i;
  logic [3:0]        ev_way_i;
  logic              ev_gnt_o, ev_valid_o, ev_last_o;
  logic [63:0]       ev_data_o;
  logic [49:0]       ev_tag_o;
  logic              fill_req_i, fill_valid_i;
  logic [7:0]        fill_index_i;
  logic [3:0]        fill_way_i;
  logic [49:0]       fill_tag_i;
  logic [63:0]       fill_data_i;
  logic              fill_gnt_o, fill_ready_o, fill_done_o;
  logic [7:0]        arr_index_o;
  logic [2:0]        arr_word_sel_o;
  logic [3:0]        arr_way_sel_o;
  logic              arr_data_we_o, arr_tag_we_o;
  logic [7:0]        arr_be_o;
  logic [49:0]       arr_tag_o;
  logic [63:0]       arr_wdata_o;
  logic [63:0]       arr_rdata_i;
  logic [49:0]       arr_tag_i;
  logic              busy_o;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  cpu64_l2_line_seq dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .word_req_i(word_req_i), .word_we_i(word_we_i), .word_index_i(word_index_i),
    .word_sel_i(word_sel_i), .word_way_i(word_way_i), .word_be_i(word_be_i),
    .word_wdata_i(word_wdata_i), .word_gnt_o(word_gnt_o), .word_rdata_o(word_rdata_o),
    .ev_req_i(ev_req_i), .ev_index_i(ev_index_i), .ev_way_i(ev_way_i),
    .ev_gnt_o(ev_gnt_o), .ev_valid_o(ev_valid_o), .ev_ready_i(ev_ready_i),
    .ev_data_o(ev_data_o), .ev_tag_o(ev_tag_o), .ev_last_o(ev_last_o),
    .fill_req_i(fill_req_i), .fill_index_i(fill_index_i), .fill_way_i(fill_way_i),
    .fill_tag_i(fill_tag_i), .fill_gnt_o(fill_gnt_o), .fill_valid_i(fill_valid_i),
    .fill_data_i(fill_data_i), .fill_ready_o(fill_ready_o), .fill_done_o(fill_done_o),
    .arr_index_o(arr_index_o), .arr_word_sel_o(arr_word_sel_o),
    .arr_way_sel_o(arr_way_sel_o), .arr_data_we_o(arr_data_we_o),
    .arr_tag_we_o(arr_tag_we_o), .arr_be_o(arr_be_o), .arr_tag_o(arr_tag_o),
    .arr_wdata_o(arr_wdata_o), .arr_rdata_i(arr_rdata_i), .arr_tag_i(arr_tag_i),
    .busy_o(busy_o)
  );

  // ---------------- shared helpers ----------------
  function automatic bit [63:0] init_word(logic [14:0] a);
    return {32'(a) * 32'h9E3779B9 ^ 32'h5A5A1234, ~(32'(a) * 32'h85EBCA6B)};
  endfunction

  function automatic bit [49:0] init_tag(logic [11:0] t);
    return {t, 38'h2A55555555} ^ 50'(t);
  endfunction

  function automatic bit [63:0] merge(bit [63:0] old, bit [63:0] nw, bit [7:0] be);
    bit [63:0] r;
    r = old;
    for (int i = 0; i < 8; i++) if (be[i]) r[i*8 +: 8] = nw[i*8 +: 8];
    return r;
  endfunction

  function automatic logic [14:0] waddr(logic [7:0] idx, logic [3:0] way, logic [2:0] w);
    return {idx, way, w};
  endfunction

  function automatic logic [11:0] taddr(logic [7:0] idx, logic [3:0] way);
    return {idx, way};
  endfunction

  // ---------------- array environment (driven by DUT port) ----------------
  bit [63:0] env_mem  [0:32767];
  bit        env_wr   [0:32767];
  bit [49:0] env_tag  [0:4095];
  bit        env_twr  [0:4095];
  logic [14:0] env_a;
  logic [11:0] env_t;

  assign env_a       = {arr_index_o, arr_way_sel_o, arr_word_sel_o};
  assign env_t       = {arr_index_o, arr_way_sel_o};
  assign arr_rdata_i = env_wr[env_a]  ? env_mem[env_a] : init_word(env_a);
  assign arr_tag_i   = env_twr[env_t] ? env_tag[env_t] : init_tag(env_t);

  always @(posedge clk_i) begin
    if (arr_data_we_o) begin
      env_mem[env_a] = merge(arr_rdata_i, arr_wdata_o, arr_be_o);
      env_wr[env_a]  = 1'b1;
    end
    if (arr_tag_we_o) begin
      env_tag[env_t] = arr_tag_o;
      env_twr[env_t] = 1'b1;
    end
  end

  // ---------------- reference image (updated from transactions) ----------------
  bit [63:0] ref_mem [0:32767];
  bit [49:0] ref_tag [0:4095];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_word(input bit we, input logic [7:0] idx, input logic [2:0] sel,
                          input logic [3:0] way, input logic [7:0] be, input logic [63:0] d);
    word_req_i = 1'b1; word_we_i = we; word_index_i = idx; word_sel_i = sel;
    word_way_i = way;  word_be_i = be; word_wdata_i = d;
  endtask

  task automatic set_word_rand();
    set_word(1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), 3'($urandom),
             4'($urandom), 8'($urandom), {$urandom, $urandom});
  endtask

  // Called at an observation point where the pending word must be granted now.
  task automatic word_expect(input string tag);
    logic [14:0] a;
    a = waddr(word_index_i, word_way_i, word_sel_i);
    check({tag, "_gnt"}, {ev_gnt_o, fill_gnt_o, word_gnt_o}, 3'b001);
    check({tag, "_we"}, arr_data_we_o, word_we_i);
    check({tag, "_addr"}, {arr_index_o, arr_way_sel_o, arr_word_sel_o}, a);
    if (word_we_i) begin
      check({tag, "_be"}, arr_be_o, word_be_i);
      check({tag, "_wdata"}, arr_wdata_o, word_wdata_i);
      ref_mem[a] = merge(ref_mem[a], word_wdata_i, word_be_i);
    end else begin
      check({tag, "_rdata"}, word_rdata_o, ref_mem[a]);
    end
  endtask

  // Starts right after the grant edge; ends at the first IDLE observation.
  // mode 0: ready toggles 1,0,1,...; otherwise random ready.
  task automatic ev_beats(input logic [7:0] idx, input logic [3:0] way,
                          input int mode, input bit drop);
    int b = 0;
    int n = 0;
    bit rdy;
    while (b < 8 && n < 64) begin
      @(negedge clk_i);
      if (drop) ev_req_i = 1'b0;
      rdy = (mode == 0) ? (n % 2 == 0) : ($urandom_range(0, 1) == 1);
      ev_ready_i = rdy;
      #1;
      check("ev_valid", ev_valid_o, 1'b1);
      check("ev_data", ev_data_o, ref_mem[waddr(idx, way, 3'(b))]);
      check("ev_tag", ev_tag_o, ref_tag[taddr(idx, way)]);
      check("ev_last", ev_last_o, b == 7);
      check("ev_no_write", {arr_data_we_o, arr_tag_we_o}, 2'b00);
      check("ev_busy_no_gnt", {ev_gnt_o, fill_gnt_o, word_gnt_o}, 3'b000);
      if (rdy) b++;
      n++;
    end
    check("ev_beat_budget", b, 8);
    @(negedge clk_i);
    ev_ready_i = 1'b0;
    #1;
    check("ev_end_idle", {busy_o, ev_valid_o}, 2'b00);
  endtask

  // Same framing as ev_beats. abort_at >= 0 asserts reset on that beat.
  task automatic fill_beats(input logic [7:0] idx, input logic [3:0] way,
                            input logic [49:0] tag, input bit gaps,
                            input bit drop, input int abort_at);
    int b = 0;
    int n = 0;
    bit v;
    logic [63:0] d;
    while (b < 8 && n < 64) begin
      @(negedge clk_i);
      if (drop) fill_req_i = 1'b0;
      v = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      d = {$urandom, $urandom};
      fill_valid_i = v;
      fill_data_i  = d;
      if (v && b == abort_at) begin
        rst_i = 1'b1;
        #1;
        check("rst_fill_busy", busy_o, 1'b0);
        check("rst_fill_ready", fill_ready_o, 1'b0);
        check("rst_fill_we", {arr_data_we_o, arr_tag_we_o}, 2'b00);
        check("rst_fill_done", fill_done_o, 1'b0);
        @(negedge clk_i);
        rst_i = 1'b0;
        fill_valid_i = 1'b0;
        #1;
        check("rst_fill_done_after", {fill_done_o, busy_o}, 2'b00);
        @(negedge clk_i);
        #1;
        check("rst_fill_done_after2", fill_done_o, 1'b0);
        return;
      end
      #1;
      check("fill_ready", fill_ready_o, 1'b1);
      check("fill_data_we", arr_data_we_o, v);
      check("fill_tag_we", arr_tag_we_o, v && b == 7);
      check("fill_busy_no_gnt", {ev_gnt_o, fill_gnt_o, word_gnt_o}, 3'b000);
      if (v) begin
        check("fill_addr", {arr_index_o, arr_way_sel_o, arr_word_sel_o}, waddr(idx, way, 3'(b)));
        check("fill_be", arr_be_o, 8'hFF);
        check("fill_wdata", arr_wdata_o, d);
        ref_mem[waddr(idx, way, 3'(b))] = d;
        if (b == 7) begin
          check("fill_tag", arr_tag_o, tag);
          ref_tag[taddr(idx, way)] = tag;
        end
        b++;
      end
      n++;
    end
    check("fill_beat_budget", b, 8);
    @(negedge clk_i);
    fill_valid_i = 1'b0;
    #1;
    check("fill_done_pulse", fill_done_o, 1'b1);
    check("fill_end_idle", busy_o, 1'b0);
  endtask

  task automatic wait_grant(input int which, input string tag);
    int n = 0;
    logic [2:0] exp;
    exp = (which == 0) ? 3'b100 : (which == 1) ? 3'b010 : 3'b001;
    while ({ev_gnt_o, fill_gnt_o, word_gnt_o} != exp && n < 16) begin
      @(negedge clk_i);
      #1;
      n++;
    end
    check(tag, {ev_gnt_o, fill_gnt_o, word_gnt_o}, exp);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] prior;
    logic [49:0] t;

    for (int i = 0; i < 32768; i++) ref_mem[i] = init_word(15'(i));
    for (int i = 0; i < 4096; i++)  ref_tag[i] = init_tag(12'(i));

    rst_i = 1'b1;
    word_req_i = 1'b1; word_we_i = 1'b1; word_index_i = '0; word_sel_i = '0;
    word_way_i = '0; word_be_i = '0; word_wdata_i = '0;
    ev_req_i = 1'b1; ev_index_i = '0; ev_way_i = '0; ev_ready_i = 1'b0;
    fill_req_i = 1'b1; fill_index_i = '0; fill_way_i = '0; fill_tag_i = '0;
    fill_valid_i = 1'b0; fill_data_i = '0;

    // Reset with every request asserted: nothing may be granted.
    @(negedge clk_i);
    #1;
    check("rst_gnts", {ev_gnt_o, fill_gnt_o, word_gnt_o}, 3'b000);
    check("rst_status", {busy_o, ev_valid_o, fill_ready_o, fill_done_o}, 4'b0000);
    check("rst_we", {arr_data_we_o, arr_tag_we_o}, 2'b00);
    @(negedge clk_i);
    ev_req_i = 1'b0; fill_req_i = 1'b0; word_req_i = 1'b0;
    rst_i = 1'b0;
    #1;
    check("post_rst_idle", {busy_o, ev_gnt_o, fill_gnt_o, word_gnt_o}, 4'b0000);

    // Partial-byte word write then read back.
    @(negedge clk_i);
    prior = ref_mem[waddr(8'd5, 4'd3, 3'd2)];
    set_word(1'b1, 8'd5, 3'd2, 4'd3, 8'h0F, 64'h1122334455667788);
    #1;
    word_expect("word_wr");
    @(negedge clk_i);
    set_word(1'b0, 8'd5, 3'd2, 4'd3, 8'h00, 64'h0);
    #1;
    word_expect("word_rd");
    check("word_rd_merge", word_rdata_o, {prior[63:32], 32'h55667788});
    @(negedge clk_i);
    word_req_i = 1'b0;

    // Eviction with ready toggling.
    @(negedge clk_i);
    ev_req_i = 1'b1; ev_index_i = 8'd9; ev_way_i = 4'd7;
    #1;
    wait_grant(0, "ev_gnt");
    ev_beats(8'd9, 4'd7, 0, 1'b1);

    // Refill with gaps, then evict to see the new line.
    @(negedge clk_i);
    fill_req_i = 1'b1; fill_index_i = 8'd9; fill_way_i = 4'd7;
    fill_tag_i = 50'h3_0000_0000_0001;
    #1;
    wait_grant(1, "fill_gnt");
    fill_beats(8'd9, 4'd7, 50'h3_0000_0000_0001, 1'b1, 1'b1, -1);
    @(negedge clk_i);
    ev_req_i = 1'b1; ev_index_i = 8'd9; ev_way_i = 4'd7;
    #1;
    check("fill_done_clears", fill_done_o, 1'b0);
    wait_grant(0, "ev_after_fill_gnt");
    ev_beats(8'd9, 4'd7, 1, 1'b1);

    // All three at once: ev, then word (boost), then fill.
    @(negedge clk_i);
    ev_req_i = 1'b1; ev_index_i = 8'd20; ev_way_i = 4'd1;
    t = {$urandom, $urandom};
    fill_req_i = 1'b1; fill_index_i = 8'd21; fill_way_i = 4'd2; fill_tag_i = t;
    set_word(1'b0, 8'd9, 3'd4, 4'd7, 8'h00, 64'h0);
    #1;
    check("tri_first_ev", {ev_gnt_o, fill_gnt_o, word_gnt_o}, 3'b100);
    ev_beats(8'd20, 4'd1, 1, 1'b1);
    word_expect("tri_word_second");
    @(negedge clk_i);
    word_req_i = 1'b0;
    #1;
    check("tri_fill_third", {ev_gnt_o, fill_gnt_o, word_gnt_o}, 3'b010);
    fill_beats(8'd21, 4'd2, t, 1'b1, 1'b1, -1);

    // Reset on fill beat 4: no tag install, no done pulse.
    @(negedge clk_i);
    t = {$urandom, $urandom};
    fill_req_i = 1'b1; fill_index_i = 8'd30; fill_way_i = 4'd5; fill_tag_i = t;
    #1;
    wait_grant(1, "abort_fill_gnt");
    fill_beats(8'd30, 4'd5, t, 1'b0, 1'b1, 4);
    @(negedge clk_i);
    ev_req_i = 1'b1; ev_index_i = 8'd30; ev_way_i = 4'd5;
    #1;
    wait_grant(0, "abort_ev_gnt");
    ev_beats(8'd30, 4'd5, 1, 1'b1);

    // Continuous ev/fill traffic with a word always pending.
    @(negedge clk_i);
    ev_req_i = 1'b1; ev_index_i = 8'd40; ev_way_i = 4'd9;
    t = {$urandom, $urandom};
    fill_req_i = 1'b1; fill_index_i = 8'd41; fill_way_i = 4'd11; fill_tag_i = t;
    set_word_rand();
    #1;
    for (int r = 0; r < 3; r++) begin
      check("starve_ev_gnt", {ev_gnt_o, fill_gnt_o, word_gnt_o}, 3'b100);
      ev_beats(8'd40, 4'd9, 1, 1'b0);
      word_expect("starve_word_after_ev");
      @(negedge clk_i);
      set_word_rand();
      if (r == 2) ev_req_i = 1'b0;
      #1;
    end
    check("starve_fill_gnt", {ev_gnt_o, fill_gnt_o, word_gnt_o}, 3'b010);
    fill_beats(8'd41, 4'd11, t, 1'b1, 1'b1, -1);
    word_expect("starve_word_after_fill");
    @(negedge clk_i);
    word_req_i = 1'b0;
    #1;
    check("final_idle", {busy_o, ev_gnt_o, fill_gnt_o, word_gnt_o}, 4'b0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu64_l2_line_seq.md
Name: cpu64_l2_line_seq

Overview:
Sequencer and arbiter in front of the L2 data/tag arrays (256 sets, 16 ways, 8×64b words per line, 50b tags). Shares the single array port between three requesters: core word access, victim eviction burst and refill burst. Generates per-beat index/word/way/enable signals. Array reads are combinational, so read data is valid in the same cycle its address is driven.

Parameters:
DATA_W, 64, word width
TAG_W, 50, tag width
IDX_W, 8, set index width
WAY_W, 4, way select width
BEATS, 8, words per line (beat counter 3b)

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-high reset
word_req_i  in  1  core single-word access request, held until granted
word_we_i  in  1  1=write, 0=read
word_index_i  in  IDX_W  set
word_sel_i  in  3  word in line
word_way_i  in  WAY_W  way
word_be_i  in  8  byte enables
word_wdata_i  in  DATA_W  write data
word_gnt_o  out  1  access performed this cycle
word_rdata_o  out  DATA_W  read data, valid when word_gnt_o
ev_req_i  in  1  eviction request, held until granted
ev_index_i  in  IDX_W  victim set
ev_way_i  in  WAY_W  victim way
ev_gnt_o  out  1  eviction accepted
ev_valid_o  out  1  eviction beat valid
ev_ready_i  in  1  downstream accepts beat
ev_data_o  out  DATA_W  beat data
ev_tag_o  out  TAG_W  victim tag, valid with ev_valid_o
ev_last_o  out  1  beat 7
fill_req_i  in  1  refill request, held until granted
fill_index_i  in  IDX_W  target set
fill_way_i  in  WAY_W  target way
fill_tag_i  in  TAG_W  new tag
fill_gnt_o  out  1  refill accepted
fill_valid_i  in  1  refill beat valid
fill_data_i  in  DATA_W  refill beat data
fill_ready_o  out  1  sequencer accepts refill beat
fill_done_o  out  1  one-cycle pulse after final beat written
arr_index_o  out  IDX_W  to arrays
arr_word_sel_o  out  3  to arrays
arr_way_sel_o  out  WAY_W  to arrays
arr_data_we_o  out  1  to arrays
arr_tag_we_o  out  1  to arrays
arr_be_o  out  8  to arrays
arr_tag_o  out  TAG_W  to arrays
arr_wdata_o  out  DATA_W  to arrays
arr_rdata_i  in  DATA_W  selected word from arrays
arr_tag_i  in  TAG_W  selected tag from arrays
busy_o  out  1  state != IDLE

Behaviour:
- States: IDLE, EVICT, FILL. Registers: state, beat_q[2:0], latched idx/way (and fill tag), word_prio_q, done_q.
- Reset (async, rst_i high): state=IDLE, beat_q=0, word_prio_q=0, done_q=0. All grants, ev_valid_o, fill_ready_o, fill_done_o, arr_data_we_o, arr_tag_we_o and busy_o are 0; all grants are masked while rst_i=1.
- IDLE arbitration is combinational; grants are one-hot. Default priority: ev > fill > word. If word_prio_q=1 and word_req_i=1, word wins.
- Word grant: arrays are driven from word_* inputs the same cycle. data_we = word_we_i, be = word_be_i. word_rdata_o = arr_rdata_i. State stays IDLE.
- ev grant: latch index/way, beat_q=0, go to EVICT. fill grant: latch index/way/tag, beat_q=0, go to FILL.
- EVICT: arrays driven with latched idx/way and word=beat_q, no writes. ev_valid_o=1, ev_data_o=arr_rdata_i, ev_tag_o=arr_tag_i, ev_last_o=(beat_q==7).
  - On ev_valid_o & ev_ready_i: beat_q++. On the last beat, go to IDLE and set word_prio_q.
  - Stall (ev_ready_i=0) holds everything.
- FILL: fill_ready_o=1. On fill_valid_i: arr_data_we_o=1, be=8'hFF, word=beat_q, wdata=fill_data_i, beat_q++.
  - On beat 7, arr_tag_we_o=1 with arr_tag_o=latched tag in the same cycle, then go to IDLE, set word_prio_q and done_q.
  - fill_done_o = done_q, which clears next cycle.
  - The tag is written only on the final beat, so a partial fill never installs a tag.
- word_prio_q clears on a word grant, or in IDLE when word_req_i=0.
- Requests arriving while busy are ignored until IDLE. They are not queued internally; requesters hold.
- beat_q wraps 7→0 at burst end.
- Reset mid-burst: immediate return to IDLE, no further array writes, and no fill_done_o pulse.
- Outside active use, arr_* data/address outputs are don't-care but enables are 0.

Decomposition:
- Shared package: state encoding localparams, BEATS, widths, FULL_BE = 8'hFF.
- One natural sub-module: cpu64_l2_arb3, a combinational fixed-priority arbiter with a boost input (word_prio_q) producing one-hot grants.
- The rest is one FSM file.

Test Plan:
- Reset then word write idx=5, word=2, way=3, be=0x0F, data=0x1122334455667788 → word_gnt_o=1 same cycle, arr_data_we_o=1. Read back gives word_rdata_o=0x????????55667788 with the upper bytes at their prior value.
- ev_req idx=9, way=7 with ev_ready_i toggling 1,0,1,… → 8 beats words 0..7 in order, ev_last_o only on beat 7, data stable across stalls, busy_o low after the last beat.
- fill_req idx=9, way=7, tag=0x3_0000_0000_0001 with gaps in fill_valid_i → data writes only on valid cycles, tag write coincident with beat 7, fill_done_o pulses 1 cycle later. A subsequent eviction returns the filled data and tag.
- ev_req, fill_req and word_req together at IDLE → ev granted first. After the eviction the word is granted before the fill. The fill follows.
- Assert rst_i during fill beat 4 → no tag write and no fill_done_o. The tag at idx/way keeps its old value, and busy_o=0 immediately.
- Continuous ev_req and fill_req with word_req held → the word is granted within one IDLE cycle after each burst (no starvation).
